// File: rtl/e203_eai_csr_resp_if.sv
// EAI custom-CSR channel between the ALU CSR controller (master) and the
// coprocessor-side CSR bank (slave).
interface e203_eai_csr_resp_if;
    logic        eai_csr_valid;
    logic        eai_csr_ready;
    logic [31:0] eai_csr_addr;
    logic        eai_csr_wr;
    logic [31:0] eai_csr_wdata;
    logic [31:0] eai_csr_rdata;

    modport master (
        output eai_csr_valid,
        output eai_csr_addr,
        output eai_csr_wr,
        output eai_csr_wdata,
        input  eai_csr_ready,
        input  eai_csr_rdata
    );

    modport slave (
        input  eai_csr_valid,
        input  eai_csr_addr,
        input  eai_csr_wr,
        input  eai_csr_wdata,
        output eai_csr_ready,
        output eai_csr_rdata
    );
endinterface

// File: rtl/e203_eai_csr_resp.sv
// Coprocessor-side CSR bank for the 0xE00-0xEFF EAI CSR space: one access at a
// time, WAIT_CYC wait states, combinational completion with read data.
module e203_eai_csr_resp #(
    parameter int unsigned WAIT_CYC = 1,
    parameter logic [31:0] ID_VAL   = 32'hE203_EA10
) (
    input  logic                      clk,
    input  logic                      rst,
    e203_eai_csr_resp_if.slave        csr,
    input  logic                      eai_disable,
    output logic                      eai_xs_off
);

    localparam logic [11:0] A_SCR0  = 12'hE00;
    localparam logic [11:0] A_SCR1  = 12'hE01;
    localparam logic [11:0] A_SCR2  = 12'hE02;
    localparam logic [11:0] A_SCR3  = 12'hE03;
    localparam logic [11:0] A_CYCLE = 12'hE04;
    localparam logic [11:0] A_CTRL  = 12'hE05;
    localparam logic [11:0] A_WRCNT = 12'hE06;
    localparam logic [11:0] A_ID    = 12'hE07;

    // Counter preload for the first WAIT cycle; unused when there are no wait states.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 32'd0) ? 4'(WAIT_CYC - 32'd1) : 4'd0;
    localparam logic       NO_WAIT   = (WAIT_CYC == 32'd0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0][31:0]  scr_q, scr_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic [31:0]       wrcnt_q, wrcnt_d;
    logic              xs_off_q, xs_off_d;

    logic              ready_s;
    logic              commit_s;
    logic              rw_hit_s;
    logic [11:0]       idx_s;
    logic [31:0]       rdata_raw_s;
    logic              unused_addr_s;

    assign idx_s         = csr.eai_csr_addr[11:0];
    assign unused_addr_s = ^csr.eai_csr_addr[31:12];

    // Access sequencing: wait-state counting, flush on dropped valid, completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csr.eai_csr_valid) begin
                    if (NO_WAIT) begin
                        ready_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_WAIT: begin
                if (!csr.eai_csr_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    ready_s = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign commit_s = csr.eai_csr_valid & ready_s & csr.eai_csr_wr;
    assign rw_hit_s = (idx_s >= A_SCR0) && (idx_s <= A_CTRL);

    // Read decode returns the pre-write, pre-increment register value.
    always_comb begin
        rdata_raw_s = 32'd0;
        case (idx_s)
            A_SCR0:  rdata_raw_s = scr_q[0];
            A_SCR1:  rdata_raw_s = scr_q[1];
            A_SCR2:  rdata_raw_s = scr_q[2];
            A_SCR3:  rdata_raw_s = scr_q[3];
            A_CYCLE: rdata_raw_s = cycle_q;
            A_CTRL:  rdata_raw_s = {31'd0, ctrl_en_q};
            A_WRCNT: rdata_raw_s = wrcnt_q;
            A_ID:    rdata_raw_s = ID_VAL;
            default: rdata_raw_s = 32'd0;
        endcase
    end

    // Register bank next state; a write to CYCLE overrides that cycle's increment.
    always_comb begin
        scr_d     = scr_q;
        ctrl_en_d = ctrl_en_q;
        wrcnt_d   = wrcnt_q;
        if (ctrl_en_q) begin
            cycle_d = cycle_q + 32'd1;
        end else begin
            cycle_d = cycle_q;
        end
        if (commit_s) begin
            case (idx_s)
                A_SCR0:  scr_d[0]  = csr.eai_csr_wdata;
                A_SCR1:  scr_d[1]  = csr.eai_csr_wdata;
                A_SCR2:  scr_d[2]  = csr.eai_csr_wdata;
                A_SCR3:  scr_d[3]  = csr.eai_csr_wdata;
                A_CYCLE: cycle_d   = csr.eai_csr_wdata;
                A_CTRL:  ctrl_en_d = csr.eai_csr_wdata[0];
                default: ctrl_en_d = ctrl_en_q;
            endcase
            if (rw_hit_s) begin
                wrcnt_d = wrcnt_q + 32'd1;
            end else begin
                wrcnt_d = wrcnt_q;
            end
        end else begin
            wrcnt_d = wrcnt_q;
        end
    end

    assign xs_off_d = eai_disable;

    // State and register bank flops; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            scr_q     <= '0;
            cycle_q   <= 32'd0;
            ctrl_en_q <= 1'b1;
            wrcnt_q   <= 32'd0;
            xs_off_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scr_q     <= scr_d;
            cycle_q   <= cycle_d;
            ctrl_en_q <= ctrl_en_d;
            wrcnt_q   <= wrcnt_d;
            xs_off_q  <= xs_off_d;
        end
    end

    assign csr.eai_csr_ready = ready_s;
    assign csr.eai_csr_rdata = ready_s ? rdata_raw_s : 32'd0;
    assign eai_xs_off        = xs_off_q;

endmodule

// File: tb/tb_e203_eai_csr_resp.sv
// Directed bench for e203_eai_csr_resp: three instances with WAIT_CYC = 1, 3, 0
// share stimulus; sel picks which one sees valid and whose response is checked.
module tb_e203_eai_csr_resp;

    logic        clk;
    logic        rst;
    logic        eai_disable;
    logic        tb_valid;
    logic [31:0] tb_addr;
    logic        tb_wr;
    logic [31:0] tb_wdata;
    logic [1:0]  sel;
    logic        xs_off0, xs_off1, xs_off2;
    logic        mux_ready;
    logic [31:0] mux_rdata;
    int          chk_cnt;
    int          err_cnt;

    e203_eai_csr_resp_if if0 ();
    e203_eai_csr_resp_if if1 ();
    e203_eai_csr_resp_if if2 ();

    assign if0.eai_csr_valid = tb_valid && (sel == 2'd0);
    assign if1.eai_csr_valid = tb_valid && (sel == 2'd1);
    assign if2.eai_csr_valid = tb_valid && (sel == 2'd2);
    assign if0.eai_csr_addr  = tb_addr;
    assign if1.eai_csr_addr  = tb_addr;
    assign if2.eai_csr_addr  = tb_addr;
    assign if0.eai_csr_wr    = tb_wr;
    assign if1.eai_csr_wr    = tb_wr;
    assign if2.eai_csr_wr    = tb_wr;
    assign if0.eai_csr_wdata = tb_wdata;
    assign if1.eai_csr_wdata = tb_wdata;
    assign if2.eai_csr_wdata = tb_wdata;

    assign mux_ready = (sel == 2'd0) ? if0.eai_csr_ready :
                       (sel == 2'd1) ? if1.eai_csr_ready : if2.eai_csr_ready;
    assign mux_rdata = (sel == 2'd0) ? if0.eai_csr_rdata :
                       (sel == 2'd1) ? if1.eai_csr_rdata : if2.eai_csr_rdata;

    e203_eai_csr_resp #(.WAIT_CYC(1), .ID_VAL(32'hE203_EA10)) u_dut_w1 (
        .clk(clk), .rst(rst), .csr(if0.slave), .eai_disable(eai_disable), .eai_xs_off(xs_off0));
    e203_eai_csr_resp #(.WAIT_CYC(3), .ID_VAL(32'hE203_EA10)) u_dut_w3 (
        .clk(clk), .rst(rst), .csr(if1.slave), .eai_disable(eai_disable), .eai_xs_off(xs_off1));
    e203_eai_csr_resp #(.WAIT_CYC(0), .ID_VAL(32'hE203_EA10)) u_dut_w0 (
        .clk(clk), .rst(rst), .csr(if2.slave), .eai_disable(eai_disable), .eai_xs_off(xs_off2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until ready (bounded), checks gating, read data and wait count.
    task automatic do_access(input string tag, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input bit chk_rd,
                             input logic [31:0] exp_rd, input int exp_lat);
        int lat;
        bit done;
        lat  = 0;
        done = 1'b0;
        tb_valid = 1'b1;
        tb_addr  = a;
        tb_wr    = w;
        tb_wdata = d;
        while (!done && lat < 40) begin
            #3;
            if (mux_ready) begin
                if (chk_rd) check({tag, "_rdata"}, mux_rdata, exp_rd);
                done = 1'b1;
            end else begin
                check({tag, "_gate"}, mux_rdata, 32'd0);
                lat++;
            end
            tick();
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic idle(input int n);
        tb_valid = 1'b0;
        tb_wr    = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_cnt     = 0;
        err_cnt     = 0;
        rst         = 1'b1;
        eai_disable = 1'b0;
        tb_valid    = 1'b0;
        tb_addr     = 32'd0;
        tb_wr       = 1'b0;
        tb_wdata    = 32'd0;
        sel         = 2'd0;

        // Reset state
        #2;
        check("rst_xs0", {31'd0, xs_off0}, 32'd1);
        check("rst_xs1", {31'd0, xs_off1}, 32'd1);
        check("rst_xs2", {31'd0, xs_off2}, 32'd1);
        check("rst_ready", {31'd0, mux_ready}, 32'd0);
        check("rst_rdata", mux_rdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #3;
        check("rel_xs_hold", {31'd0, xs_off0}, 32'd1);
        tick();
        check("rel_xs_clr", {31'd0, xs_off0}, 32'd0);
        eai_disable = 1'b1;
        #3;
        check("dis_xs_before", {31'd0, xs_off1}, 32'd0);
        tick();
        check("dis_xs_after", {31'd0, xs_off1}, 32'd1);
        eai_disable = 1'b0;
        tick();
        check("en_xs_after", {31'd0, xs_off2}, 32'd0);

        // WAIT_CYC = 1: ID/CTRL/SCR reads, write-back, RO and unmapped writes
        sel = 2'd0;
        do_access("w1_id",     32'h0000_0E07, 1'b0, 32'd0,         1'b1, 32'hE203_EA10, 1);
        do_access("w1_ctrl",   32'h0000_0E05, 1'b0, 32'd0,         1'b1, 32'd1,         1);
        do_access("w1_scr0",   32'h0000_0E00, 1'b0, 32'd0,         1'b1, 32'd0,         1);
        do_access("w1_wr2",    32'h0000_0E02, 1'b1, 32'hDEADBEEF,  1'b1, 32'd0,         1);
        do_access("w1_rd2",    32'h0000_0E02, 1'b0, 32'd0,         1'b1, 32'hDEADBEEF,  1);
        do_access("w1_rd2hi",  32'h1234_5E02, 1'b0, 32'd0,         1'b1, 32'hDEADBEEF,  1);
        do_access("w1_wrcnt1", 32'h0000_0E06, 1'b0, 32'd0,         1'b1, 32'd1,         1);
        do_access("w1_wr_id",  32'h0000_0E07, 1'b1, 32'h0000_0001, 1'b1, 32'hE203_EA10, 1);
        do_access("w1_wr_e10", 32'h0000_0E10, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd0,         1);
        do_access("w1_wr_wc",  32'h0000_0E06, 1'b1, 32'h0000_0055, 1'b1, 32'd1,         1);
        do_access("w1_wrcnt2", 32'h0000_0E06, 1'b0, 32'd0,         1'b1, 32'd1,         1);
        do_access("w1_rd_e10", 32'h0000_0E10, 1'b0, 32'd0,         1'b1, 32'd0,         1);
        do_access("w1_id_ro",  32'h0000_0E07, 1'b0, 32'd0,         1'b1, 32'hE203_EA10, 1);
        idle(2);

        // WAIT_CYC = 3: flushed write must not commit
        sel = 2'd1;
        tb_valid = 1'b1;
        tb_addr  = 32'h0000_0E00;
        tb_wr    = 1'b1;
        tb_wdata = 32'd5;
        #3;
        check("fl_ready0", {31'd0, mux_ready}, 32'd0);
        tick();
        #3;
        check("fl_ready1", {31'd0, mux_ready}, 32'd0);
        tick();
        idle(1);
        do_access("w3_scr0",  32'h0000_0E00, 1'b0, 32'd0, 1'b1, 32'd0, 3);
        do_access("w3_wrcnt", 32'h0000_0E06, 1'b0, 32'd0, 1'b1, 32'd0, 3);
        idle(1);

        // WAIT_CYC = 0: back-to-back writes to SCR1
        sel = 2'd2;
        do_access("w0_b2b1", 32'h0000_0E01, 1'b1, 32'd1, 1'b1, 32'd0, 0);
        do_access("w0_b2b2", 32'h0000_0E01, 1'b1, 32'd2, 1'b1, 32'd1, 0);
        do_access("w0_b2b3", 32'h0000_0E01, 1'b1, 32'd3, 1'b1, 32'd2, 0);
        do_access("w0_b2b4", 32'h0000_0E01, 1'b1, 32'd4, 1'b1, 32'd3, 0);
        do_access("w0_wrcnt", 32'h0000_0E06, 1'b0, 32'd0, 1'b1, 32'd4, 0);
        do_access("w0_scr1", 32'h0000_0E01, 1'b0, 32'd0, 1'b1, 32'd4, 0);

        // CYCLE: write wins over increment, wrap, freeze via CTRL
        do_access("cy_wr",    32'h0000_0E04, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0,         0);
        do_access("cy_rd0",   32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'hFFFF_FFFE, 0);
        do_access("cy_rd1",   32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'hFFFF_FFFF, 0);
        do_access("cy_wrap",  32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'd0,         0);
        do_access("cy_stop",  32'h0000_0E05, 1'b1, 32'd0,         1'b1, 32'd1,         0);
        do_access("cy_frz0",  32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'd2,         0);
        do_access("cy_frz1",  32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'd2,         0);
        do_access("cy_wrfz",  32'h0000_0E04, 1'b1, 32'h0000_0010, 1'b1, 32'd2,         0);
        do_access("cy_start", 32'h0000_0E05, 1'b1, 32'd1,         1'b1, 32'd0,         0);
        do_access("cy_run0",  32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'h0000_0010, 0);
        do_access("cy_run1",  32'h0000_0E04, 1'b0, 32'd0,         1'b1, 32'h0000_0011, 0);
        do_access("cy_wrcnt", 32'h0000_0E06, 1'b0, 32'd0,         1'b1, 32'd8,         0);
        idle(1);

        // Reset while WAIT_CYC = 3 access sits in WAIT
        sel = 2'd1;
        tb_valid = 1'b1;
        tb_addr  = 32'h0000_0E01;
        tb_wr    = 1'b1;
        tb_wdata = 32'd7;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mr_ready", {31'd0, mux_ready}, 32'd0);
        check("mr_xs", {31'd0, xs_off1}, 32'd1);
        tb_valid = 1'b0;
        tb_wr    = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_access("mr_scr1",  32'h0000_0E01, 1'b0, 32'd0, 1'b1, 32'd0, 3);
        do_access("mr_wrcnt", 32'h0000_0E06, 1'b0, 32'd0, 1'b1, 32'd0, 3);
        do_access("mr_ctrl",  32'h0000_0E05, 1'b0, 32'd0, 1'b1, 32'd1, 3);
        idle(1);
        sel = 2'd2;
        do_access("mr_w0_scr1", 32'h0000_0E01, 1'b0, 32'd0, 1'b1, 32'd0, 0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
